// File: rtl/degamma_sched.sv
// -----------------------------------------------------------------------------
// degamma_sched
//
// Converts one RGB666 gamma-encoded pixel into linear RGB888 by time-sharing a
// single external degamma LUT. The channels go through the LUT one per cycle
// in R, G, B order. The finished pixel is then presented downstream.
//
// Handshake semantics (both sides): a transfer happens at a rising clk edge
// where valid && ready are both high. A valid output stays asserted, and its
// data stays stable, until it transfers. An upstream pixel is sampled only at
// its transfer edge.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset; drops any in-flight pixel
//   s_valid    in   upstream pixel valid
//   s_ready    out  upstream ready (IDLE, or OUT while downstream is ready)
//   s_r/g/b    in   6-bit gamma-encoded channels
//   lut_in     out  6-bit index into the shared LUT (0 when not converting)
//   lut_out    in   8-bit linear value for lut_in, same cycle
//   m_valid    out  downstream pixel valid
//   m_ready    in   downstream ready
//   m_r/g/b    out  8-bit linear channels, registered
//   dbg_state  out  current FSM state (IDLE=0, CH_R=1, CH_G=2, CH_B=3, OUT=4)
//   bypass     in   (only with DEGAMMA_SCHED_BYPASS_EN) per-pixel LUT bypass
//
// Optional feature: define DEGAMMA_SCHED_BYPASS_EN to add the bypass input.
// When bypass is set, each channel becomes the 6-to-8-bit replication
// {x, x[5:4]} instead of the LUT value. Timing and lut_in stay the same.
// -----------------------------------------------------------------------------
module degamma_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [5:0] s_r,
  input  logic [5:0] s_g,
  input  logic [5:0] s_b,
`ifdef DEGAMMA_SCHED_BYPASS_EN
  input  logic       bypass,
`endif
  output logic [5:0] lut_in,
  input  logic [7:0] lut_out,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_r,
  output logic [7:0] m_g,
  output logic [7:0] m_b,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CH_R = 3'd1,
    ST_CH_G = 3'd2,
    ST_CH_B = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] r_q, g_q, b_q;
  logic [7:0] m_r_q, m_g_q, m_b_q;
  logic       capture;
  logic       ld_r, ld_g, ld_b;
  logic [7:0] chan_val;

`ifdef DEGAMMA_SCHED_BYPASS_EN
  logic bypass_q;
  // lut_in carries the channel under conversion, so it is also the bypass source.
  assign chan_val = bypass_q ? {lut_in, lut_in[5:4]} : lut_out;
`else
  assign chan_val = lut_out;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    lut_in  = 6'd0;
    capture = 1'b0;
    ld_r    = 1'b0;
    ld_g    = 1'b0;
    ld_b    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          capture = 1'b1;
          state_d = ST_CH_R;
        end
      end
      ST_CH_R: begin
        lut_in  = r_q;
        ld_r    = 1'b1;
        state_d = ST_CH_G;
      end
      ST_CH_G: begin
        lut_in  = g_q;
        ld_g    = 1'b1;
        state_d = ST_CH_B;
      end
      ST_CH_B: begin
        lut_in  = b_q;
        ld_b    = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        // A new pixel is taken on the same edge the current one leaves.
        // This gives one pixel every four cycles with no idle gap.
        s_ready = m_ready;
        if (m_ready) begin
          if (s_valid) begin
            capture = 1'b1;
            state_d = ST_CH_R;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= 6'd0;
      g_q     <= 6'd0;
      b_q     <= 6'd0;
      m_r_q   <= 8'd0;
      m_g_q   <= 8'd0;
      m_b_q   <= 8'd0;
`ifdef DEGAMMA_SCHED_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        r_q <= s_r;
        g_q <= s_g;
        b_q <= s_b;
`ifdef DEGAMMA_SCHED_BYPASS_EN
        bypass_q <= bypass;
`endif
      end
      if (ld_r) m_r_q <= chan_val;
      if (ld_g) m_g_q <= chan_val;
      if (ld_b) m_b_q <= chan_val;
    end
  end

  assign m_r       = m_r_q;
  assign m_g       = m_g_q;
  assign m_b       = m_b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_degamma_sched.sv
// -----------------------------------------------------------------------------
// tb_degamma_sched
//
// Bench for degamma_sched. It supplies the degamma LUT as a combinational
// table of round(255 * (x/63)^2.2). The reference model is a pixel queue.
// Each accepted pixel is converted by the LUT rule and stored with its accept
// cycle. From that it is known which channel should be on lut_in and when the
// pixel must appear downstream. Directed scenarios come first, then a random
// run with random back-pressure, occasional resets and changing inputs.
// -----------------------------------------------------------------------------
module tb_degamma_sched;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [5:0] s_r, s_g, s_b;
  logic [5:0] lut_in;
  logic [7:0] lut_out;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_r, m_g, m_b;
  logic [2:0] dbg_state;
`ifdef DEGAMMA_SCHED_BYPASS_EN
  logic       bypass;
`endif

  logic [7:0] lut_tbl [64];

  // Scoreboard state
  logic [23:0] exp_q[$];   // expected {m_r, m_g, m_b}
  logic [17:0] raw_q[$];   // accepted {r, g, b}
  int          acc_q[$];   // cycle index of the accepting edge
  int          cyc;
  int          tests;
  int          fails;

  degamma_sched dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_r       (s_r),
    .s_g       (s_g),
    .s_b       (s_b),
`ifdef DEGAMMA_SCHED_BYPASS_EN
    .bypass    (bypass),
`endif
    .lut_in    (lut_in),
    .lut_out   (lut_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_r       (m_r),
    .m_g       (m_g),
    .m_b       (m_b),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared LUT
  always_comb lut_out = lut_tbl[lut_in];

  function automatic logic [23:0] convert(input logic [17:0] px, input logic byp);
    logic [5:0] c [3];
    logic [23:0] res;
    c[0] = px[17:12];
    c[1] = px[11:6];
    c[2] = px[5:0];
    res = 24'd0;
    for (int k = 0; k < 3; k++) begin
      res = res << 8;
      res[7:0] = byp ? {c[k], c[k][5:4]} : lut_tbl[c[k]];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_px(input logic v, input logic [5:0] r, input logic [5:0] g,
                          input logic [5:0] b);
    s_valid = v;
    s_r     = r;
    s_g     = g;
    s_b     = b;
  endtask

  // One clock cycle. Outputs are checked against the model at the falling
  // edge. The model then advances using the handshakes of the rising edge.
  task automatic tick();
    logic       exp_mv, exp_sr, xfer, acc, byp;
    logic [5:0] exp_li;
    int         d;
    @(negedge clk);
    exp_mv = 1'b0;
    exp_li = 6'd0;
    if (exp_q.size() > 0) begin
      d = cyc - acc_q[0];
      exp_mv = (d >= 4);
      if (d == 1) exp_li = raw_q[0][17:12];
      if (d == 2) exp_li = raw_q[0][11:6];
      if (d == 3) exp_li = raw_q[0][5:0];
    end
    exp_sr = (exp_q.size() == 0) || (exp_mv && m_ready);
    check("m_valid", {23'd0, m_valid}, {23'd0, exp_mv});
    check("s_ready", {23'd0, s_ready}, {23'd0, exp_sr});
    check("lut_in", {18'd0, lut_in}, {18'd0, exp_li});
    if (exp_mv) check("m_pixel", {m_r, m_g, m_b}, exp_q[0]);
    xfer = exp_mv && m_ready;
    acc  = s_valid && exp_sr && !rst;
`ifdef DEGAMMA_SCHED_BYPASS_EN
    byp = bypass;
`else
    byp = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      raw_q.delete();
      acc_q.delete();
    end else begin
      if (xfer) begin
        void'(exp_q.pop_front());
        void'(raw_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(convert({s_r, s_g, s_b}, byp));
        raw_q.push_back({s_r, s_g, s_b});
        acc_q.push_back(cyc);
      end
    end
    cyc++;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    cyc     = 0;
    rst     = 1'b1;
    m_ready = 1'b0;
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
`ifdef DEGAMMA_SCHED_BYPASS_EN
    bypass = 1'b0;
`endif
    for (int i = 0; i < 64; i++)
      lut_tbl[i] = 8'($rtoi(255.0 * ((i / 63.0) ** 2.2) + 0.5));

    // Reset. The first edges are not modelled because the DUT state is unknown.
    repeat (2) @(posedge clk);
    #1;
    // The last reset cycle offers a pixel that must not be accepted.
    drive_px(1'b1, 6'd33, 6'd44, 6'd55);
    tick();
    rst = 1'b0;
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    check("rst_m_valid", {23'd0, m_valid}, 24'd0);
    check("rst_m_pixel", {m_r, m_g, m_b}, 24'd0);
    check("rst_s_ready", {23'd0, s_ready}, 24'd1);
    check("rst_lut_in", {18'd0, lut_in}, 24'd0);
    repeat (3) tick();

    // Single pixel (63,32,0) with downstream ready.
    m_ready = 1'b1;
    drive_px(1'b1, 6'd63, 6'd32, 6'd0);
    tick();
    drive_px(1'b0, 6'd7, 6'd7, 6'd7);
    repeat (3) tick();
    check("single_valid", {23'd0, m_valid}, 24'd1);
    check("single_pixel", {m_r, m_g, m_b}, {8'd255, 8'd57, 8'd0});
    tick();
    check("single_idle_valid", {23'd0, m_valid}, 24'd0);
    check("single_idle_ready", {23'd0, s_ready}, 24'd1);
    check("single_idle_lut", {18'd0, lut_in}, 24'd0);
    repeat (2) tick();

    // Back-to-back pixels, four cycles apart.
    drive_px(1'b1, 6'd46, 6'd20, 6'd4);
    tick();
    drive_px(1'b1, 6'd1, 6'd63, 6'd12);
    repeat (3) tick();
    check("b2b_first", {m_r, m_g, m_b}, {8'd128, 8'd20, 8'd1});
    tick();
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    check("b2b_gap_valid", {23'd0, m_valid}, 24'd0);
    repeat (3) tick();
    check("b2b_second_valid", {23'd0, m_valid}, 24'd1);
    check("b2b_second", {m_r, m_g, m_b}, {8'd0, 8'd255, 8'd7});
    repeat (2) tick();

    // Back-pressure for six cycles, then an accept on the releasing edge.
    m_ready = 1'b0;
    drive_px(1'b1, 6'd10, 6'd40, 6'd60);
    tick();
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", {23'd0, m_valid}, 24'd1);
      check("stall_pixel", {m_r, m_g, m_b}, {8'd4, 8'd94, 8'd229});
      check("stall_s_ready", {23'd0, s_ready}, 24'd0);
      tick();
    end
    m_ready = 1'b1;
    drive_px(1'b1, 6'd5, 6'd9, 6'd17);
    #1;
    check("release_s_ready", {23'd0, s_ready}, 24'd1);
    tick();
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    check("release_lut_r", {18'd0, lut_in}, 24'd5);
    repeat (5) tick();

    // Reset while the green channel is being converted.
    drive_px(1'b1, 6'd50, 6'd50, 6'd50);
    tick();
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {23'd0, m_valid}, 24'd0);
    check("midrst_pixel", {m_r, m_g, m_b}, 24'd0);
    check("midrst_s_ready", {23'd0, s_ready}, 24'd1);
    repeat (6) tick();

`ifdef DEGAMMA_SCHED_BYPASS_EN
    // Bypass pixel, then the same pixel through the LUT.
    bypass = 1'b1;
    drive_px(1'b1, 6'd63, 6'd32, 6'd1);
    tick();
    bypass = 1'b0;
    drive_px(1'b1, 6'd63, 6'd32, 6'd1);
    repeat (3) tick();
    check("bypass_pixel", {m_r, m_g, m_b}, {8'd255, 8'd130, 8'd4});
    tick();
    drive_px(1'b0, 6'd0, 6'd0, 6'd0);
    repeat (3) tick();
    check("bypass_off_pixel", {m_r, m_g, m_b}, {8'd255, 8'd57, 8'd0});
    repeat (2) tick();
`endif

    // Random traffic with back-pressure, input churn and occasional resets.
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_r     = 6'($urandom_range(0, 63));
      s_g     = 6'($urandom_range(0, 63));
      s_b     = 6'($urandom_range(0, 63));
      m_ready = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 59) == 0);
`ifdef DEGAMMA_SCHED_BYPASS_EN
      bypass  = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    // Drain the pipeline.
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (8) tick();
    check("drain_empty", {23'd0, m_valid}, 24'd0);
    check("drain_queue", 24'(exp_q.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
